// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshakes; shifts run one bit per cycle.
// Define ALU_OVF_EN to build the signed-overflow flag for ADD/SUB; otherwise Overflow is tied to 0.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [3:0]         ALU_Control,
  input  logic [WIDTH-1:0]   Operand_A,
  input  logic [WIDTH-1:0]   Operand_B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               Overflow,
  output logic               Busy
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shift_left_q, shift_left_d;
  logic               zero_q, zero_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               is_shift;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   acc_next;

  assign In_Ready  = (state_q == IDLE) && !Reset;
  assign accept    = In_Valid && In_Ready;
  assign is_shift  = (ALU_Control == OP_SLL) || (ALU_Control == OP_SRL);
  assign sum       = Operand_A + Operand_B;
  assign diff      = Operand_A - Operand_B;
  assign acc_next  = shift_left_q ? (acc_q << 1) : (acc_q >> 1);

  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Out_Valid = out_valid_q;
  assign Busy      = (state_q == SHIFT);

  always_comb begin
    alu_res = '0;
    case (ALU_Control)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_SLL:  alu_res = Operand_B;
      OP_SRL:  alu_res = Operand_B;
      OP_AND:  alu_res = Operand_A & Operand_B;
      OP_OR:   alu_res = Operand_A | Operand_B;
      OP_NOR:  alu_res = ~(Operand_A | Operand_B);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (Operand_A < Operand_B)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(Operand_A) < $signed(Operand_B))};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic alu_ovf;

  // Signed overflow: result sign disagrees with what the operand signs imply.
  always_comb begin
    alu_ovf = 1'b0;
    if (ALU_Control == OP_ADD)
      alu_ovf = (Operand_A[WIDTH-1] == Operand_B[WIDTH-1]) && (sum[WIDTH-1] != Operand_A[WIDTH-1]);
    else if (ALU_Control == OP_SUB)
      alu_ovf = (Operand_A[WIDTH-1] != Operand_B[WIDTH-1]) && (diff[WIDTH-1] != Operand_A[WIDTH-1]);
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    shift_left_d = shift_left_q;
    zero_d       = zero_q;
    out_valid_d  = out_valid_q;
`ifdef ALU_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (Shamt != '0)) begin
            acc_d        = Operand_B;
            cnt_d        = Shamt;
            shift_left_d = (ALU_Control == OP_SLL);
            state_d      = SHIFT;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
            ovf_d       = alu_ovf;
`endif
            state_d     = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_next;
        cnt_d = cnt_q - SHAMT_W'(1);
        // The last shift lands straight in Result so completion costs no extra cycle.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d    = acc_next;
          zero_d      = (acc_next == '0);
          out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
          ovf_d       = 1'b0;
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (Out_Ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      result_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      shift_left_q <= 1'b0;
      zero_q       <= 1'b0;
      out_valid_q  <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      shift_left_q <= shift_left_d;
      zero_q       <= zero_d;
      out_valid_q  <= out_valid_d;
`ifdef ALU_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued on accept and
// compared whenever the DUT hands a result downstream.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;

  exp_t sb_q[$];
  int   test_count = 0;
  int   fail_count = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .Clk(clk), .Reset(rst), .In_Valid(in_valid), .In_Ready(in_ready),
    .ALU_Control(alu_control), .Operand_A(operand_a), .Operand_B(operand_b),
    .Shamt(shamt), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Result(result), .Zero(zero), .Overflow(overflow), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model works on the whole shift at once and on 64-bit signed sums.
  function automatic exp_t modelAlu(input logic [3:0] code, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, full;
    logic   ovf_raw;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf_raw = 1'b0;
    e.res = 32'h0;
    case (code)
      4'd1: begin e.res = a + b; full = sa + sb; ovf_raw = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      4'd2: begin e.res = a - b; full = sa - sb; ovf_raw = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      4'd3: e.res = b << sh;
      4'd4: e.res = b >> sh;
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: e.res = ~(a | b);
      4'd8: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd9: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: e.res = 32'h0;
    endcase
    e.zero = (e.res == 32'h0);
`ifdef ALU_OVF_EN
    e.ovf = ovf_raw;
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Waits for In_Ready, presents one operation for one cycle, optionally queues its expectation.
  task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input bit push);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid    = 1'b1;
    alu_control = code;
    operand_a   = a;
    operand_b   = b;
    shamt       = sh;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb_q.push_back(modelAlu(code, a, b, sh));
  endtask

  task automatic runOp(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    int lat = 0;
    int busy_cycles = 0;
    int exp_lat;
    exp_lat = ((code == 4'd3 || code == 4'd4) && sh != 5'd0) ? int'(sh) : 0;
    applyStimulus(code, a, b, sh, 1'b1);
    while (!out_valid && lat < 100) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("latency_op%0d", code), 64'(lat), 64'(exp_lat));
    checkOutput($sformatf("busy_op%0d", code), 64'(busy_cycles), 64'(exp_lat));
    if (out_ready) begin
      @(posedge clk); #1;
      checkOutput("in_ready_after", 64'(in_ready), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("result", 64'(result), 64'(e.res));
        checkOutput("zero", 64'(zero), 64'(e.zero));
        checkOutput("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic saw_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 4'd0; operand_a = '0; operand_b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", 64'(in_ready), 64'd1);

    runOp(4'd1, 32'd5, 32'd7, 5'd0);
    runOp(4'd2, 32'h1234, 32'h1234, 5'd0);
    runOp(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd0);
    runOp(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0);
    runOp(4'd3, 32'd0, 32'h1, 5'd31);
    runOp(4'd4, 32'd0, 32'hABCD, 5'd0);
    runOp(4'd4, 32'd0, 32'h8000_00F0, 5'd4);
    runOp(4'd1, 32'h7FFF_FFFF, 32'd1, 5'd0);
    runOp(4'd2, 32'h8000_0000, 32'd1, 5'd0);
    runOp(4'd12, 32'h1111, 32'h2222, 5'd3);
    runOp(4'd0, 32'h1, 32'h1, 5'd0);
    runOp(4'd7, 32'h0F0F_0000, 32'h0000_F0F0, 5'd0);
    runOp(4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    runOp(4'd3, 32'd0, 32'h8000_0001, 5'd1);
    for (int i = 0; i < 30; i++)
      runOp(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));

    // Stalled downstream: result must hold and new offers must be refused.
    out_ready = 1'b0;
    runOp(4'd6, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; alu_control = 4'd1; operand_a = 32'd1; operand_b = 32'd1;
      @(posedge clk); #1;
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_result", 64'(result), 64'hF0F0_0F0F);
      checkOutput("hold_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("release_out_valid", 64'(out_valid), 64'd0);

    // Reset in the third SHIFT cycle of an SLL by 10 discards the operation.
    saw_valid = 1'b0;
    applyStimulus(4'd3, 32'd0, 32'h3, 5'd10, 1'b0);
    for (int i = 0; i < 2; i++) begin
      saw_valid |= out_valid;
      @(posedge clk); #1;
    end
    checkOutput("mid_shift_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid_rst_result", 64'(result), 64'd0);
    checkOutput("mid_rst_zero", 64'(zero), 64'd0);
    checkOutput("mid_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      saw_valid |= out_valid;
      @(posedge clk); #1;
    end
    checkOutput("mid_rst_no_valid", 64'(saw_valid), 64'd0);
    runOp(4'd1, 32'd100, 32'd23, 5'd0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute-stage ALU for the MIPS datapath: consumes the 4-bit operation code produced by the ALU control decoder, together with the register operands and shift amount. Produces a registered result, a zero flag and an optional overflow flag. Valid/ready handshakes are used on both sides. Shifts execute iteratively, one bit per cycle, under a small state machine; all other operations complete in one cycle.

## Interface
- WIDTH, 32, datapath width in bits
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == WIDTH
- Clk  input  1  clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- In_Valid  input  1  upstream offers an operation
- In_Ready  output  1  unit accepts an operation this cycle
- ALU_Control  input  4  1 ADD, 2 SUB, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOR, 8 SLTU, 9 SLT
- Operand_A  input  WIDTH  rs value
- Operand_B  input  WIDTH  rt value or extended immediate; this operand is the one shifted
- Shamt  input  SHAMT_W  shift amount for SLL/SRL
- Out_Valid  output  1  Result/Zero/Overflow hold a completed operation
- Out_Ready  input  1  downstream consumes the result
- Result  output  WIDTH  registered result
- Zero  output  1  registered; 1 iff Result == 0
- Overflow  output  1  registered signed overflow of ADD/SUB (see Configuration)
- Busy  output  1  1 while in SHIFT state

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- In_Ready = (state == IDLE) && !Reset. An accept occurs when In_Valid && In_Ready; operands and code are captured only on accept.
- IDLE, accept, code 3/4 with Shamt != 0: load the shift accumulator with Operand_B and the counter with Shamt, then go to SHIFT.
- IDLE, accept, any other case: compute combinationally, register Result/Zero/Overflow, set Out_Valid, then go to DONE.
- SHIFT: each cycle, shift the accumulator by 1 (SLL left, zero-fill; SRL logical right, zero-fill) and decrement the counter. When the counter reaches 1, the final shift is written to Result, Zero is updated, Overflow = 0, Out_Valid = 1, and the state goes to DONE.
- DONE: outputs held stable while !Out_Ready. On Out_Ready, Out_Valid clears and the state returns to IDLE. No accept is possible in DONE.
- Arithmetic: ADD/SUB are modulo 2**WIDTH. SLTU is an unsigned compare A<B; SLT is a signed compare. Both return 1 or 0 zero-extended to WIDTH. NOR is ~(A|B).
- Shift by 0 (code 3/4, Shamt == 0): single-cycle path, Result = Operand_B.
- Undefined codes (0, 10–15): Result = 0, Zero = 1, Overflow = 0, single-cycle path. Not an error.
- Reset mid-SHIFT or mid-DONE: the operation is discarded; the pending result is lost.

## Timing
- Reset values: Result 0, Zero 0, Overflow 0, Out_Valid 0, Busy 0, In_Ready 0 while Reset is asserted and 1 in the first cycle after release.
- Non-shift op accepted at edge N: Out_Valid = 1 after edge N (visible in cycle N+1).
- Shift by k ≥ 1 accepted at edge N: Busy for k cycles, Out_Valid = 1 after edge N+k.
- Minimum initiation interval is 2 cycles: accept, then DONE with Out_Ready = 1, then IDLE.
- Out_Ready is ignored when Out_Valid = 0. In_Valid is ignored outside IDLE.

## Configuration
- ALU_OVF_EN defined: Overflow = 1 after ADD when the operands have the same sign and the result sign differs. After SUB, Overflow = 1 when the operands have different signs and the result sign differs from A. Overflow = 0 for all other operations.
- ALU_OVF_EN undefined: Overflow is constant 0 and no overflow logic is synthesised; all other behaviour is identical.

## Test plan
- Reset, then ADD A=5, B=7 with Out_Ready = 1 -> Out_Valid one cycle after accept, Result = 12, Zero = 0; In_Ready returns to 1 the next cycle.
- SUB A=B=0x1234 -> Result = 0, Zero = 1. SLT A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0.
- SLL B=0x1, Shamt=31 -> Busy for 31 cycles, Result = 0x80000000. SRL Shamt=0, B=0xABCD -> single-cycle, Result = 0xABCD.
- Hold Out_Ready = 0 for 5 cycles after completing an OR -> Result stable, In_Ready = 0 throughout, In_Valid pulses ignored. Release -> IDLE.
- ADD A=0x7FFFFFFF, B=1 -> Result = 0x80000000, Overflow = 1 with ALU_OVF_EN and 0 without. Code 12 -> Result = 0, Zero = 1.
- Assert Reset at SHIFT cycle 3 of an SLL by 10 -> Out_Valid never rises, all outputs return to reset values, and the next ADD completes normally.
